// File: rtl/bit_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serial_pkg
//  Description : Shared types and constants for the bit-serial add/subtract
//                datapath (FSM state encoding, operation mode codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : bit_serial_pkg
`default_nettype wire

// File: rtl/bit_serial_addsub_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module      : serial_fa_cell
//  Description : Combinational one-bit full adder, the arithmetic core of the
//                bit-serial datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule : serial_fa_cell
`default_nettype wire

// File: rtl/bit_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serial_addsub
//  Description : Bit-serial adder/subtractor. Operands are shifted LSB-first
//                through one full-adder cell with a registered carry; the
//                parallel result, carry-out and signed overflow are presented
//                with a one-cycle done pulse. Subtraction is A + ~B + 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_addsub
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_data_sum,
    output logic             o_data_carry,
    output logic             o_overflow
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_next;

    serial_fa_cell u_fa (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .c     (r_carry),
        .sum   (w_sum),
        .carry (w_cout)
    );

    // Result register shifts right, new sum bit enters at the MSB
    assign w_res_next = (r_res >> 1)
                      | ({{(WIDTH-1){1'b0}}, w_sum} << (WIDTH - 1));

    // Control FSM, operand/result shifting and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_a     <= i_data_a;
                        r_b     <= (i_mode == MODE_SUB) ? ~i_data_b : i_data_b;
                        // carry-in of 1 completes the two's-complement negate
                        r_carry <= i_mode;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
                        // r_carry here is the carry into the MSB position
                        r_sum   <= w_res_next;
                        r_cout  <= w_cout;
                        r_ovf   <= r_carry ^ w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_data_sum   = r_sum;
    assign o_data_carry = r_cout;
    assign o_overflow   = r_ovf;

endmodule : bit_serial_addsub
`default_nettype wire

// File: tb/tb_bit_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serial_addsub
//  Description : Directed self-checking bench for bit_serial_addsub (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_addsub;
    import bit_serial_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_sum;
    logic             data_carry;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    bit_serial_addsub #(.WIDTH(WIDTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_mode       (mode),
        .i_data_a     (data_a),
        .i_data_b     (data_b),
        .o_busy       (busy),
        .o_done       (done),
        .o_data_sum   (data_sum),
        .o_data_carry (data_carry),
        .o_overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are observed 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait (bounded) for its done pulse
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input logic [7:0] exp_sum, input logic exp_c, input logic exp_v);
        int n;
        int busy_cnt;
        data_a = a;
        data_b = b;
        mode   = m;
        start  = 1'b1;
        step();
        start    = 1'b0;
        n        = 1;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            step();
            n++;
        end
        chk("latency", n, 9);
        chk("busy_cycles", busy_cnt, 8);
        chk("done", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("sum", data_sum, exp_sum);
        chk("carry", data_carry, exp_c);
        chk("overflow", overflow, exp_v);
        step();
        chk("done_single", done, 1'b0);
    endtask

    initial begin
        int n;
        int m;
        int done_cnt;
        logic held_ok;

        rst    = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        data_a = '0;
        data_b = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", data_sum, 8'h00);
        chk("rst_carry", data_carry, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        step();

        // Basic add and subtract cases
        run_op(8'h5A, 8'h33, MODE_ADD, 8'h8D, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, MODE_ADD, 8'h00, 1'b1, 1'b0);
        run_op(8'h10, 8'h20, MODE_SUB, 8'hF0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, MODE_SUB, 8'h7F, 1'b1, 1'b1);

        // Start during RUN is ignored; operands may change mid-operation
        data_a = 8'h01;
        data_b = 8'h02;
        mode   = MODE_ADD;
        start  = 1'b1;
        step();                 // cycle 1
        start  = 1'b0;
        step();                 // cycle 2
        step();                 // cycle 3
        start  = 1'b1;
        data_a = 8'hFF;
        data_b = 8'hFF;
        step();                 // cycle 4
        start  = 1'b0;
        data_a = 8'hAA;
        data_b = 8'h55;
        mode   = MODE_SUB;
        done_cnt = 0;
        n        = 4;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("ign_latency", n, 9);
        chk("ign_sum", data_sum, 8'h03);
        chk("ign_carry", data_carry, 1'b0);
        chk("ign_ovf", overflow, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            step();
        end
        chk("ign_done_pulses", done_cnt, 1);
        chk("ign_idle_busy", busy, 1'b0);

        // Reset mid-operation aborts with no done pulse
        data_a = 8'h12;
        data_b = 8'h34;
        mode   = MODE_ADD;
        start  = 1'b1;
        step();                 // cycle 1
        start  = 1'b0;
        step();                 // cycle 2
        step();                 // cycle 3
        step();                 // cycle 4
        rst = 1'b1;
        step();                 // cycle 5
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum", data_sum, 8'h00);
        chk("abort_carry", data_carry, 1'b0);
        chk("abort_ovf", overflow, 1'b0);
        chk("abort_state", dut.r_state, IDLE);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            step();
        end
        chk("abort_no_done", done_cnt, 0);
        run_op(8'h12, 8'h34, MODE_ADD, 8'h46, 1'b0, 1'b0);

        // Back-to-back: start held high through DONE
        data_a = 8'h5A;
        data_b = 8'h33;
        mode   = MODE_ADD;
        start  = 1'b1;
        step();                 // cycle 1
        data_a = 8'h0F;
        data_b = 8'h01;
        n = 1;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("b2b_first_latency", n, 9);
        chk("b2b_first_sum", data_sum, 8'h8D);
        step();
        start = 1'b0;
        chk("b2b_no_idle_busy", busy, 1'b1);
        chk("b2b_state_run", dut.r_state, RUN);
        m       = 1;
        held_ok = 1'b1;
        while (!done && m < 20) begin
            if (data_sum !== 8'h8D) held_ok = 1'b0;
            step();
            m++;
        end
        chk("b2b_first_held", held_ok, 1'b1);
        chk("b2b_second_gap", m, 9);
        chk("b2b_second_sum", data_sum, 8'h10);
        chk("b2b_second_carry", data_carry, 1'b0);
        chk("b2b_second_ovf", overflow, 1'b0);
        step();
        chk("b2b_done_single", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bit_serial_addsub
`default_nettype wire

// File: doc/bit_serial_addsub.md
# bit_serial_addsub

Parametrised bit-serial adder/subtractor that takes two WIDTH-bit parallel operands, processes them LSB-first at one bit per clock through a single full-adder cell with a registered carry, and returns the parallel result with carry-out and signed overflow. It is the sequential successor to the team's combinational one-bit full-adder cell: it adds operand shifting, carry storage, an add/subtract mode and a start/done handshake. It sits in the bit-serial datapath wherever area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.

Ports:
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE or DONE.
- i_mode  input  1  0 = add (A+B), 1 = subtract (A−B); sampled with i_start.
- i_data_a  input  WIDTH  operand A; sampled with i_start.
- i_data_b  input  WIDTH  operand B; sampled with i_start.
- o_busy  output  1  high while the operation is in progress.
- o_done  output  1  one-cycle pulse; result valid.
- o_data_sum  output  WIDTH  result; held until the next accepted start.
- o_data_carry  output  1  carry-out of the MSB (subtract: 1 = no borrow).
- o_overflow  output  1  signed two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on i_start.
  - RUN to DONE after WIDTH bit-steps.
  - DONE to RUN if i_start is high. Otherwise DONE to IDLE.
- Start acceptance:
  - Load the A shift register with i_data_a.
  - Load the B shift register with i_data_b when i_mode = 0, or with ~i_data_b when i_mode = 1.
  - Load carry with i_mode.
  - Clear the bit counter.
  - Clear the result shift register.
- Each RUN cycle:
  - The full-adder cell sums A[0], B[0] and carry.
  - The sum bit shifts into the MSB of the result register, and the result register shifts right.
  - A and B shift right.
  - Carry is updated.
  - The counter increments.
- When the last step is taken (counter = WIDTH−1):
  - Capture carry-in to the MSB (the carry register value before that step).
  - Capture the cell's carry-out.
  - o_overflow = carry-in to MSB XOR carry-out.
  - o_data_carry = carry-out.
- Outputs are registered. o_data_sum, o_data_carry and o_overflow stay stable from the DONE cycle until the next accepted start loads new operands. They do not change during the following RUN.
- i_start during RUN is ignored, with no queueing. Operands and mode may change freely during RUN.
- Reset values: state IDLE, o_busy 0, o_done 0, o_data_sum 0, o_data_carry 0, o_overflow 0, all internal registers 0.
- Reset mid-operation aborts with no o_done pulse, and outputs return to their reset values.

## Timing
- Cycle 0: i_start high, sampled at the end of cycle 0.
- Cycles 1..WIDTH: o_busy = 1, and one bit is processed per cycle.
- Cycle WIDTH+1: o_done = 1, o_busy = 0, results valid.
- Latency from the start edge to o_done is WIDTH+1 cycles.
- Back-to-back throughput is one result per WIDTH+1 cycles: i_start high in the DONE cycle puts the block in RUN in the next cycle.
- o_done is never high for two consecutive cycles.

## Structure
- Shared package bit_serial_pkg holds:
  - typedef enum for the state (IDLE, RUN, DONE);
  - constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
- Counter width is $clog2(WIDTH), defined locally.
- One sub-module, serial_fa_cell: the combinational one-bit full adder (inputs a, b, c; outputs sum, carry), instantiated once.

## Test plan
All scenarios use WIDTH = 8.
- Add 0x5A + 0x33 -> o_data_sum 0x8D, o_data_carry 0, o_overflow 1. o_done asserts exactly 9 cycles after the start edge. o_busy is high for 8 cycles.
- Add 0xFF + 0x01 -> 0x00, carry 1, overflow 0.
- Sub 0x10 − 0x20 -> 0xF0, carry 0 (borrow), overflow 0. Then sub 0x80 − 0x01 -> 0x7F, carry 1, overflow 1.
- Start 0x01 + 0x02, pulse i_start with 0xFF + 0xFF in cycle 3, then change operand inputs -> result 0x03, with exactly one o_done pulse.
- Start an add, assert i_rst in cycle 4 -> the following cycle shows all outputs 0 and state IDLE, and no o_done pulse. A new start afterwards completes correctly.
- Hold i_start high through DONE with new operands 0x0F + 0x01 -> the next RUN begins with no IDLE cycle, and the second o_done arrives 9 cycles after the first with 0x10. The first result holds until that reload.
